// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, field positions, write masks and exception codes.
package cp0_regfile_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status field positions
  localparam int unsigned STATUS_BEV_BIT = 22;
  localparam int unsigned STATUS_IM_HI   = 15;
  localparam int unsigned STATUS_IM_LO   = 8;
  localparam int unsigned STATUS_EXL_BIT = 1;
  localparam int unsigned STATUS_IE_BIT  = 0;

  // Cause field positions
  localparam int unsigned CAUSE_BD_BIT = 31;
  localparam int unsigned CAUSE_TI_BIT = 30;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

  // Bits that MTC0 may change
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Exception codes produced by the exception controller
  typedef enum logic [4:0] {
    ExcInt  = 5'h00,
    ExcAdEL = 5'h04,
    ExcAdES = 5'h05,
    ExcSys  = 5'h08,
    ExcBp   = 5'h09,
    ExcRi   = 5'h0a,
    ExcOv   = 5'h0c
  } exccode_e;

  // Replace only the bits selected by mask
  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: half-rate Count, Compare register and sticky timer interrupt TI.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  // Next-state: Count advances on tick; a software write to Count replaces that cycle's step.
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q + {31'd0, tick_q};
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we) begin
      count_d = count_wdata;
    end
    // Match uses pre-increment registered values; a Compare write clears TI and wins over a match.
    if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
    if (compare_we) begin
      compare_d = compare_wdata;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: exception state update, MTC0/MFC0 access, timer and interrupt request.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_ena,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  input  logic        w_cp0_update_ena,
  input  logic [4:0]  w_cp0_exccode,
  input  logic        w_cp0_bd,
  input  logic        w_cp0_exl,
  input  logic [31:0] w_cp0_epc,
  input  logic        w_cp0_badvaddr_ena,
  input  logic [31:0] w_cp0_badvaddr,
  input  logic        cp0_cls_exl,
  input  logic [5:0]  hw_int,
  output logic [31:0] r_cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        int_req
);
  import cp0_regfile_pkg::*;

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;

  logic        flush;
  logic        mtc0_we;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  // An exception update or ERET flushes the instruction that issued any coincident MTC0.
  assign flush   = w_cp0_update_ena | cp0_cls_exl;
  assign mtc0_we = mtc0_ena & ~flush;

  cp0_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .count_we      (mtc0_we && (mtc0_addr == CP0_COUNT)),
    .count_wdata   (mtc0_data),
    .compare_we    (mtc0_we && (mtc0_addr == CP0_COMPARE)),
    .compare_wdata (mtc0_data),
    .count         (count),
    .compare       (compare),
    .ti            (ti)
  );

  // Next-state for Status, Cause, EPC and BadVAddr.
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    // Hardware pending bits track the lines every cycle; IP7 also carries the timer.
    ip_hw_d    = {hw_int[5] | ti, hw_int[4:0]};

    if (mtc0_we) begin
      unique case (mtc0_addr)
        CP0_STATUS: status_d = masked_write(status_q, mtc0_data, STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = mtc0_data[CAUSE_IP_LO+1:CAUSE_IP_LO];
        CP0_EPC:    epc_d    = mtc0_data;
        default:    ;
      endcase
    end

    if (w_cp0_update_ena) begin
      // A nested exception keeps the original EPC/BD so ERET returns to the outer fault.
      if (!status_q[STATUS_EXL_BIT]) begin
        bd_d  = w_cp0_bd;
        epc_d = w_cp0_epc;
      end
      status_d[STATUS_EXL_BIT] = w_cp0_exl;
      exccode_d                = w_cp0_exccode;
      if (w_cp0_badvaddr_ena) begin
        badvaddr_d = w_cp0_badvaddr;
      end
    end else if (cp0_cls_exl) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end
  end

  // Architectural register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
    end
  end

  assign cp0_status = status_q;
  assign cp0_cause  = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
  assign r_cp0_epc  = epc_q;

  // Combinational MFC0 read; unimplemented numbers read as zero.
  always_comb begin
    mfc0_data = 32'd0;
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_data = badvaddr_q;
      CP0_COUNT:    mfc0_data = count;
      CP0_COMPARE:  mfc0_data = compare;
      CP0_STATUS:   mfc0_data = cp0_status;
      CP0_CAUSE:    mfc0_data = cp0_cause;
      CP0_EPC:      mfc0_data = epc_q;
      default:      mfc0_data = 32'd0;
    endcase
  end

  assign int_req = cp0_status[STATUS_IE_BIT] & ~cp0_status[STATUS_EXL_BIT] &
                   (|(cp0_cause[CAUSE_IP_HI:CAUSE_IP_LO] & cp0_status[STATUS_IM_HI:STATUS_IM_LO]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic against a field-level model.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtc0_ena;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        w_cp0_update_ena;
  logic [4:0]  w_cp0_exccode;
  logic        w_cp0_bd;
  logic        w_cp0_exl;
  logic [31:0] w_cp0_epc;
  logic        w_cp0_badvaddr_ena;
  logic [31:0] w_cp0_badvaddr;
  logic        cp0_cls_exl;
  logic [5:0]  hw_int;
  logic [31:0] r_cp0_epc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic        int_req;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk                (clk),
    .rst                (rst),
    .mtc0_ena           (mtc0_ena),
    .mtc0_addr          (mtc0_addr),
    .mtc0_data          (mtc0_data),
    .mfc0_addr          (mfc0_addr),
    .mfc0_data          (mfc0_data),
    .w_cp0_update_ena   (w_cp0_update_ena),
    .w_cp0_exccode      (w_cp0_exccode),
    .w_cp0_bd           (w_cp0_bd),
    .w_cp0_exl          (w_cp0_exl),
    .w_cp0_epc          (w_cp0_epc),
    .w_cp0_badvaddr_ena (w_cp0_badvaddr_ena),
    .w_cp0_badvaddr     (w_cp0_badvaddr),
    .cp0_cls_exl        (cp0_cls_exl),
    .hw_int             (hw_int),
    .r_cp0_epc          (r_cp0_epc),
    .cp0_status         (cp0_status),
    .cp0_cause          (cp0_cause),
    .int_req            (int_req)
  );

  // Reference model kept as architectural fields.
  logic        m_tick;
  logic [31:0] m_count, m_compare;
  logic        m_ti;
  logic [7:0]  m_im;
  logic        m_exl, m_ie;
  logic [7:0]  m_ip;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv;

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_ie && !m_exl && ((m_ip & m_im) != 8'd0);
  endfunction

  // Advance one clock: model applies the rules to the inputs held across the edge.
  task automatic step();
    logic wr;
    @(posedge clk);
    if (rst) begin
      m_tick = 0; m_count = 0; m_compare = 0; m_ti = 0;
      m_im = 0; m_exl = 0; m_ie = 0; m_ip = 0; m_bd = 0; m_exc = 0; m_epc = 0; m_badv = 0;
    end else begin
      wr = mtc0_ena && !(w_cp0_update_ena || cp0_cls_exl);
      m_ip[7:2] = {hw_int[5] | m_ti, hw_int[4:0]};
      if (m_count == m_compare) m_ti = 1'b1;
      if (wr && mtc0_addr == 5'd11) begin
        m_ti = 1'b0;
        m_compare = mtc0_data;
      end
      if (wr && mtc0_addr == 5'd9) m_count = mtc0_data;
      else if (m_tick) m_count = m_count + 32'd1;
      m_tick = !m_tick;
      if (wr) begin
        case (mtc0_addr)
          5'd12: begin m_im = mtc0_data[15:8]; m_exl = mtc0_data[1]; m_ie = mtc0_data[0]; end
          5'd13: m_ip[1:0] = mtc0_data[9:8];
          5'd14: m_epc = mtc0_data;
          default: ;
        endcase
      end
      if (w_cp0_update_ena) begin
        if (!m_exl) begin
          m_bd  = w_cp0_bd;
          m_epc = w_cp0_epc;
        end
        m_exl = w_cp0_exl;
        m_exc = w_cp0_exccode;
        if (w_cp0_badvaddr_ena) m_badv = w_cp0_badvaddr;
      end else if (cp0_cls_exl) begin
        m_exl = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; mtc0_ena = 0; mtc0_addr = 0; mtc0_data = 0;
    w_cp0_update_ena = 0; w_cp0_exccode = 0; w_cp0_bd = 0; w_cp0_exl = 0; w_cp0_epc = 0;
    w_cp0_badvaddr_ena = 0; w_cp0_badvaddr = 0; cp0_cls_exl = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0_addr = a;
    #1;
    d = mfc0_data;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_ena = 1; mtc0_addr = a; mtc0_data = d;
    step();
    mtc0_ena = 0;
  endtask

  task automatic upd(input logic [4:0] exc, input logic bd, input logic exl, input logic [31:0] epc,
                     input logic bven, input logic [31:0] bv);
    w_cp0_update_ena = 1; w_cp0_exccode = exc; w_cp0_bd = bd; w_cp0_exl = exl; w_cp0_epc = epc;
    w_cp0_badvaddr_ena = bven; w_cp0_badvaddr = bv;
    step();
    w_cp0_update_ena = 0; w_cp0_badvaddr_ena = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [4:0]  addrs [8];
    logic [31:0] exp   [8];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    exp   = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0, 32'd0, 32'd0};
    idle(); hw_int = 0; mfc0_addr = 0;
    rst = 1; step(); step(); rst = 0;
    for (int i = 0; i < 8; i++) begin
      rd(addrs[i], d);
      n_tests++;
      if (d !== exp[i]) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got %h expected %h", addrs[i], d, exp[i]);
      end
    end
    n_tests++;
    if (int_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_int_req: got %b expected 0", int_req);
    end
  endtask

  task automatic test_count();
    logic [31:0] d;
    for (int i = 0; i < 10; i++) step();
    rd(5'd9, d);
    n_tests++;
    if (d !== 32'd5) begin
      n_fail++; $display("FAIL count_after_10: got %0d expected 5", d);
    end
  endtask

  task automatic test_timer_int();
    logic [31:0] d;
    logic found;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd20);
    found = 0;
    mfc0_addr = 5'd9;
    for (int i = 0; i < 100 && !found; i++) begin
      #1;
      if (mfc0_data == 32'd20) found = 1;
      else step();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL timer_reach20: got %0d expected 20", mfc0_data);
    end
    step();
    n_tests++;
    if (cp0_cause[30] !== 1'b1 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL timer_ti_set: ti=%b int_req=%b expected ti=1 int_req=0",
                         cp0_cause[30], int_req);
    end
    step();
    n_tests++;
    if (int_req !== 1'b1) begin
      n_fail++; $display("FAIL timer_int_req: got %b expected 1", int_req);
    end
    mtc0(5'd11, 32'd100);
    n_tests++;
    if (cp0_cause[30] !== 1'b0) begin
      n_fail++; $display("FAIL timer_ti_clear: got %b expected 0", cp0_cause[30]);
    end
    step();
    rd(5'd11, d);
    n_tests++;
    if (int_req !== 1'b0 || d !== 32'd100) begin
      n_fail++; $display("FAIL timer_int_drop: int_req=%b compare=%0d expected 0/100", int_req, d);
    end
  endtask

  task automatic test_nested_exc();
    upd(5'h0c, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 32'd0);
    n_tests++;
    if (r_cp0_epc !== 32'h8000_1000 || cp0_cause[31] !== 1'b1 || cp0_status[1] !== 1'b1 ||
        cp0_cause[6:2] !== 5'h0c) begin
      n_fail++; $display("FAIL nested_first: epc=%h cause=%h status=%h expected epc=80001000 bd=1 exl=1 exc=0c",
                         r_cp0_epc, cp0_cause, cp0_status);
    end
    upd(5'h04, 1'b0, 1'b1, 32'h8000_2000, 1'b0, 32'd0);
    n_tests++;
    if (r_cp0_epc !== 32'h8000_1000 || cp0_cause[31] !== 1'b1 || cp0_cause[6:2] !== 5'h04) begin
      n_fail++; $display("FAIL nested_second: epc=%h cause=%h expected epc=80001000 bd=1 exc=04",
                         r_cp0_epc, cp0_cause);
    end
  endtask

  task automatic test_adel();
    logic [31:0] d;
    upd(5'h04, 1'b0, 1'b1, 32'h8000_3000, 1'b1, 32'h0000_0003);
    rd(5'd8, d);
    n_tests++;
    if (d !== 32'd3 || cp0_cause[6:2] !== 5'h04) begin
      n_fail++; $display("FAIL adel: badvaddr=%h exc=%h expected 3/04", d, cp0_cause[6:2]);
    end
  endtask

  task automatic test_eret();
    cp0_cls_exl = 1; step(); cp0_cls_exl = 0;
    n_tests++;
    if (cp0_status[1] !== 1'b0 || r_cp0_epc !== 32'h8000_1000) begin
      n_fail++; $display("FAIL eret: exl=%b epc=%h expected 0/80001000", cp0_status[1], r_cp0_epc);
    end
  endtask

  task automatic test_collision();
    mtc0_ena = 1; mtc0_addr = 5'd14; mtc0_data = 32'h0000_1234;
    upd(5'h00, 1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'd0);
    mtc0_ena = 0;
    n_tests++;
    if (r_cp0_epc !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL collision_epc: got %h expected bfc00000", r_cp0_epc);
    end
    cp0_cls_exl = 1; step(); cp0_cls_exl = 0;
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    #1;
    n_tests++;
    if (int_req !== 1'b0) begin
      n_fail++; $display("FAIL hwint_before: got %b expected 0", int_req);
    end
    step();
    n_tests++;
    if (int_req !== 1'b1) begin
      n_fail++; $display("FAIL hwint_after: got %b expected 1", int_req);
    end
    hw_int = 0;
    step();
  endtask

  task automatic test_masks();
    logic [31:0] d;
    mtc0(5'd12, 32'hFFFF_FFFF);
    n_tests++;
    if (cp0_status !== 32'h0040_FF03) begin
      n_fail++; $display("FAIL status_mask: got %h expected 0040ff03", cp0_status);
    end
    mtc0(5'd12, 32'h0000_0000);
    n_tests++;
    if (cp0_status !== 32'h0040_0000) begin
      n_fail++; $display("FAIL status_bev: got %h expected 00400000", cp0_status);
    end
    mtc0(5'd13, 32'hFFFF_FFFF);
    n_tests++;
    if (cp0_cause !== m_cause() || cp0_cause[9:8] !== 2'b11) begin
      n_fail++; $display("FAIL cause_mask: got %h expected %h", cp0_cause, m_cause());
    end
    mtc0(5'd13, 32'h0000_0000);
    mtc0(5'd8, 32'hDEAD_BEEF);
    rd(5'd8, d);
    n_tests++;
    if (d !== 32'd3) begin
      n_fail++; $display("FAIL badvaddr_ro: got %h expected 3", d);
    end
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, d);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL count_load: got %h expected ffffffff", d);
    end
    step(); step();
    rd(5'd9, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL count_wrap: got %h expected 0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [4:0]  regs [7];
    logic [4:0]  ra;
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      mtc0_ena = ($urandom_range(0, 2) == 0);
      mtc0_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
      mtc0_data = ($urandom_range(0, 3) == 0) ? m_count + 32'($urandom_range(0, 3)) : $urandom;
      w_cp0_update_ena = ($urandom_range(0, 9) == 0);
      w_cp0_exccode = 5'($urandom);
      w_cp0_bd = 1'($urandom);
      w_cp0_exl = ($urandom_range(0, 3) != 0);
      w_cp0_epc = $urandom;
      w_cp0_badvaddr_ena = 1'($urandom);
      w_cp0_badvaddr = $urandom;
      cp0_cls_exl = ($urandom_range(0, 9) == 0);
      hw_int = 6'($urandom);
      step();
      ra = regs[$urandom_range(0, 6)];
      rd(ra, d);
      n_tests++;
      if (d !== m_read(ra)) begin
        n_fail++; $display("FAIL rand_mfc0[%0d] cyc %0d: got %h expected %h", ra, i, d, m_read(ra));
      end
      n_tests++;
      if (cp0_status !== m_status() || cp0_cause !== m_cause() || r_cp0_epc !== m_epc) begin
        n_fail++; $display("FAIL rand_regs cyc %0d: status=%h/%h cause=%h/%h epc=%h/%h (got/expected)",
                           i, cp0_status, m_status(), cp0_cause, m_cause(), r_cp0_epc, m_epc);
      end
      n_tests++;
      if (int_req !== m_int()) begin
        n_fail++; $display("FAIL rand_int_req cyc %0d: got %b expected %b", i, int_req, m_int());
      end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_count();
    test_timer_int();
    test_nested_exc();
    test_adel();
    test_eret();
    test_collision();
    test_masks();
    test_count_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
